// File: rtl/boid_frame_scheduler.sv
// Frame-synchronous boid rasteriser: clears the back buffer, draws a
// square sprite per active boid, then swaps front/back display buffers.
module boid_frame_scheduler #(
  parameter int NUM_BOIDS = 8,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int ADDR_W    = 19,
  parameter int SPRITE    = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         frame_end,
  input  logic [$clog2(NUM_BOIDS):0]   boid_count,
  output logic [$clog2(NUM_BOIDS)-1:0] boid_sel,
  input  logic [9:0]                   boid_x,
  input  logic [8:0]                   boid_y,
  output logic                         fb_clear,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_waddr,
  output logic                         front_sel,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   overrun_cnt
);

  localparam int IW = $clog2(NUM_BOIDS);
  localparam int CW = IW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_SWAP  = 2'd3;

  localparam logic [CW-1:0] NMAX  = CW'(NUM_BOIDS);
  localparam logic [1:0]    SLAST = 2'(SPRITE - 1);
  localparam logic [10:0]   HLIM  = 11'(H_RES);
  localparam logic [9:0]    VLIM  = 10'(V_RES);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [IW-1:0]     i_q, i_d;
  logic [1:0]        dx_q, dx_d;
  logic [1:0]        dy_q, dy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              front_q, front_d;
  logic              done_q, done_d;
  logic [7:0]        ovr_q, ovr_d;

  logic [10:0]       px;
  logic [9:0]        py;
  logic              in_bounds;
  logic              last_boid;
  logic [ADDR_W-1:0] pix_addr;

  // widened sums so sprites at the screen edge clip instead of wrapping
  assign px        = {1'b0, boid_x} + {9'b0, dx_q};
  assign py        = {1'b0, boid_y} + {8'b0, dy_q};
  assign in_bounds = (px < HLIM) && (py < VLIM);
  assign pix_addr  = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
  assign last_boid = ({1'b0, i_q} == n_q - CW'(1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    front_d = front_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (frame_end && state_q != S_IDLE && ovr_q != 8'hff)
      ovr_d = ovr_q + 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (frame_end) begin
          n_d     = (boid_count > NMAX) ? NMAX : boid_count;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        i_d     = '0;
        dx_d    = '0;
        dy_d    = '0;
        state_d = (n_q != '0) ? S_DRAW : S_SWAP;
      end
      S_DRAW: begin
        we_d = in_bounds;
        if (in_bounds)
          waddr_d = pix_addr;
        if (dx_q != SLAST) begin
          dx_d = dx_q + 2'd1;
        end else begin
          dx_d = '0;
          if (dy_q != SLAST) begin
            dy_d = dy_q + 2'd1;
          end else begin
            dy_d = '0;
            if (last_boid) begin
              i_d     = '0;
              state_d = S_SWAP;
            end else begin
              i_d = i_q + IW'(1);
            end
          end
        end
      end
      S_SWAP: begin
        front_d = ~front_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      front_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      front_q <= front_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign boid_sel    = i_q;
  assign fb_clear    = (state_q == S_CLEAR);
  assign busy        = (state_q != S_IDLE);
  assign fb_we       = we_q;
  assign fb_waddr    = waddr_q;
  assign front_sel   = front_q;
  assign done        = done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Randomised bench for boid_frame_scheduler against a pixel-list model.
// Each scenario task drives a frame and checks its own observations.
module tb_boid_frame_scheduler;

  localparam int NB = 8;
  localparam int SP = 2;
  localparam int HR = 640;
  localparam int VR = 480;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_end;
  logic [3:0]  boid_count;
  logic [2:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        fb_clear;
  logic        fb_we;
  logic [18:0] fb_waddr;
  logic        front_sel;
  logic        busy;
  logic        done;
  logic [7:0]  overrun_cnt;

  logic [9:0] bx [NB];
  logic [8:0] by [NB];

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_end   (frame_end),
    .boid_count  (boid_count),
    .boid_sel    (boid_sel),
    .boid_x      (boid_x),
    .boid_y      (boid_y),
    .fb_clear    (fb_clear),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .front_sel   (front_sel),
    .busy        (busy),
    .done        (done),
    .overrun_cnt (overrun_cnt)
  );

  always #10 clock = ~clock;

  int vec = 0;
  int err = 0;
  int exp_q [$];
  int addr_q [$];
  int sel_q [$];
  int obs_busy, obs_clear, obs_done, obs_done_k, obs_inj;
  int exp_front = 0;
  int exp_ovr = 0;
  int exp_n;

  // pixel list the frame should produce, in draw order
  task automatic build_exp(input int cnt);
    int x, y;
    exp_q.delete();
    exp_n = (cnt > NB) ? NB : cnt;
    for (int i = 0; i < exp_n; i++)
      for (int dy = 0; dy < SP; dy++)
        for (int dx = 0; dx < SP; dx++) begin
          x = int'(bx[i]) + dx;
          y = int'(by[i]) + dy;
          if (x < HR && y < VR) exp_q.push_back(y * HR + x);
        end
  endtask

  function automatic int first_diff();
    if (addr_q.size() != exp_q.size()) return 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (addr_q[i] != exp_q[i]) return i;
    return -1;
  endfunction

  task automatic run_frame(input int cnt, input int extra);
    int len, inj;
    build_exp(cnt);
    len = 2 + exp_n * SP * SP;
    addr_q.delete();
    sel_q.delete();
    obs_busy = 0; obs_clear = 0; obs_done = 0; obs_done_k = -1; inj = 0;
    @(negedge clock);
    boid_count = 4'(cnt);
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    boid_count = 4'($urandom_range(0, 15));
    for (int k = 0; k < 200; k++) begin
      if (busy) obs_busy++;
      if (fb_clear) obs_clear++;
      if (fb_we) addr_q.push_back(int'(fb_waddr));
      if (busy && k >= 1) sel_q.push_back(int'(boid_sel));
      if (done) begin
        obs_done++;
        if (obs_done_k < 0) obs_done_k = k;
      end
      if (k >= 1 && k < len && inj < extra) begin
        frame_end = 1'b1;
        inj++;
      end else begin
        frame_end = 1'b0;
      end
      if (obs_done_k >= 0 && k >= obs_done_k + 3) break;
      @(negedge clock);
    end
    frame_end = 1'b0;
    obs_inj = inj;
    exp_front ^= 1;
    exp_ovr = (exp_ovr + inj > 255) ? 255 : exp_ovr + inj;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_end = 1'b0; boid_count = '0;
    for (int i = 0; i < NB; i++) begin bx[i] = '0; by[i] = '0; end
    #25;
    vec++; if ({busy, fb_clear, fb_we, done, front_sel} !== 5'b0) begin
      err++; $display("FAIL reset_flags got %b want 00000",
        {busy, fb_clear, fb_we, done, front_sel});
    end
    vec++; if (fb_waddr !== 19'd0) begin
      err++; $display("FAIL reset_waddr got %0d want 0", fb_waddr);
    end
    vec++; if (boid_sel !== 3'd0 || overrun_cnt !== 8'd0) begin
      err++; $display("FAIL reset_cnt got sel=%0d ovr=%0d want 0/0",
        boid_sel, overrun_cnt);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_empty();
    run_frame(0, 0);
    vec++; if (obs_clear !== 1) begin
      err++; $display("FAIL empty_clear got %0d want 1", obs_clear);
    end
    vec++; if (addr_q.size() !== 0) begin
      err++; $display("FAIL empty_writes got %0d want 0", addr_q.size());
    end
    vec++; if (obs_busy !== 2 || obs_done_k !== 2) begin
      err++; $display("FAIL empty_timing got busy=%0d done_k=%0d want 2/2",
        obs_busy, obs_done_k);
    end
    vec++; if (int'(front_sel) !== exp_front) begin
      err++; $display("FAIL empty_front got %0d want %0d", front_sel, exp_front);
    end
  endtask

  task automatic test_single();
    bx[0] = 10'd10; by[0] = 9'd5;
    run_frame(1, 0);
    vec++; if (first_diff() != -1) begin
      err++; $display("FAIL single_writes got %p want %p", addr_q, exp_q);
    end
    vec++; if (addr_q.size() != 4 || addr_q[0] != 3210 || addr_q[3] != 3851) begin
      err++; $display("FAIL single_addr got %p want 3210..3851", addr_q);
    end
    vec++; if (obs_busy !== 6 || obs_done !== 1) begin
      err++; $display("FAIL single_busy got %0d/%0d want 6/1", obs_busy, obs_done);
    end
    vec++; if (int'(front_sel) !== exp_front) begin
      err++; $display("FAIL single_front got %0d want %0d", front_sel, exp_front);
    end
  endtask

  task automatic test_corner();
    bx[0] = 10'd639; by[0] = 9'd479;
    run_frame(1, 0);
    vec++; if (addr_q.size() != 1 || addr_q[0] != 307199) begin
      err++; $display("FAIL corner_writes got %p want 307199", addr_q);
    end
    vec++; if (obs_busy !== 6) begin
      err++; $display("FAIL corner_busy got %0d want 6", obs_busy);
    end
  endtask

  task automatic test_clamp();
    int bad;
    for (int i = 0; i < NB; i++) begin
      bx[i] = 10'($urandom_range(0, 639));
      by[i] = 9'($urandom_range(0, 479));
    end
    run_frame(12, 0);
    vec++; if (obs_busy !== 34) begin
      err++; $display("FAIL clamp_busy got %0d want 34", obs_busy);
    end
    bad = -1;
    for (int k = 0; k < 32; k++)
      if (bad < 0 && (k >= sel_q.size() || sel_q[k] != k / (SP * SP))) bad = k;
    vec++; if (bad != -1) begin
      err++; $display("FAIL clamp_sel first bad draw cycle %0d got %p", bad, sel_q);
    end
    vec++; if (first_diff() != -1) begin
      err++; $display("FAIL clamp_writes got %0d want %0d writes",
        addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NB; i++) begin
        bx[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(630, 639))
                                            : 10'($urandom_range(0, 639));
        by[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(470, 479))
                                            : 9'($urandom_range(0, 479));
      end
      run_frame($urandom_range(0, 15), 0);
      vec++; if (first_diff() != -1 || obs_busy != 2 + exp_n * SP * SP) begin
        err++; $display("FAIL random_frame%0d got %0d writes busy=%0d want %0d busy=%0d",
          f, addr_q.size(), obs_busy, exp_q.size(), 2 + exp_n * SP * SP);
      end
      vec++; if (int'(front_sel) !== exp_front || obs_done !== 1) begin
        err++; $display("FAIL random_swap%0d got front=%0d done=%0d want %0d/1",
          f, front_sel, obs_done, exp_front);
      end
    end
  endtask

  task automatic test_overrun();
    int remaining;
    run_frame(2, 3);
    vec++; if (int'(overrun_cnt) !== exp_ovr || obs_inj != 3) begin
      err++; $display("FAIL overrun3 got %0d want %0d", overrun_cnt, exp_ovr);
    end
    vec++; if (obs_done !== 1 || obs_busy !== 10 || obs_clear !== 1) begin
      err++; $display("FAIL overrun_norestart got done=%0d busy=%0d clr=%0d want 1/10/1",
        obs_done, obs_busy, obs_clear);
    end
    remaining = 300;
    while (remaining > 0) begin
      run_frame(8, remaining);
      remaining -= obs_inj;
      vec++; if (int'(overrun_cnt) !== exp_ovr) begin
        err++; $display("FAIL overrun_run got %0d want %0d", overrun_cnt, exp_ovr);
      end
    end
    vec++; if (overrun_cnt !== 8'd255) begin
      err++; $display("FAIL overrun_sat got %0d want 255", overrun_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    boid_count = 4'd8;
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    repeat (1 + 3 * SP * SP) @(negedge clock);
    vec++; if (boid_sel !== 3'd3 || !busy) begin
      err++; $display("FAIL mid_sel got %0d busy=%0d want 3/1", boid_sel, busy);
    end
    reset_n = 1'b0;
    #1;
    vec++; if ({busy, fb_clear, fb_we, done, front_sel} !== 5'b0 ||
               boid_sel !== 3'd0 || fb_waddr !== 19'd0 || overrun_cnt !== 8'd0) begin
      err++; $display("FAIL mid_reset got flags=%b sel=%0d addr=%0d ovr=%0d want all 0",
        {busy, fb_clear, fb_we, done, front_sel}, boid_sel, fb_waddr, overrun_cnt);
    end
    exp_front = 0;
    exp_ovr = 0;
    @(negedge clock);
    reset_n = 1'b1;
    run_frame(8, 0);
    vec++; if (sel_q.size() == 0 || sel_q[0] != 0 || first_diff() != -1) begin
      err++; $display("FAIL mid_fresh got %0d writes want %0d from boid 0",
        addr_q.size(), exp_q.size());
    end
    vec++; if (int'(front_sel) !== exp_front || obs_busy !== 34) begin
      err++; $display("FAIL mid_front got front=%0d busy=%0d want %0d/34",
        front_sel, obs_busy, exp_front);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_corner();
    test_clamp();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
